// File: rtl/fp_mult_pkg.sv
// fp_mult_pkg: arbiter states, operand/result byte counts and the canonical quiet NaN
package fp_mult_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, WAIT, COLLECT, DRAIN, RESP} state_t;
  localparam int FP_IN_BYTES = 16;
  localparam int FP_OUT_BYTES = 8;
  localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;
  function automatic logic [2:0] oh2idx(input logic [7:0] oh);
    oh2idx = '0;
    for (int i = 0; i < 8; i++) oh2idx |= oh[i] ? 3'(i) : 3'd0;
  endfunction
endpackage

// File: rtl/fp_mult_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick; the first request after ptr (wrapping) wins
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         win
);
  localparam int IW = $clog2(NUM_REQ);
  logic [IW-1:0] k;
  // Scan farthest-first so the nearest pending client after ptr overwrites last
  always_comb begin
    win = '0;
    k = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      k = IW'((int'(ptr) + i) % NUM_REQ);
      if (req[k]) win = NUM_REQ'(1) << k;
    end
  end
endmodule

// File: rtl/fp_mult_arbiter.sv
// fp_mult_arbiter: shares one byte-serial fp_mult among NUM_REQ clients, round-robin.
// Define FP_MULT_ARB_TIMEOUT_EN to abort a stuck job after TIMEOUT cycles with a NaN/error response.
module fp_mult_arbiter
  import fp_mult_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [64*NUM_REQ-1:0] req_a,
  input  logic [64*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    res_valid,
  output logic [63:0]           res_data,
  output logic                  res_err,
  output logic                  mul_reset,
  output logic                  mul_enable,
  output logic [7:0]            mul_data_in,
  input  logic [7:0]            mul_data_out,
  input  logic                  mul_ready
);
  localparam int IW = $clog2(NUM_REQ);
  state_t state_q, state_d;
  logic [IW-1:0] ptr, widx;
  logic [NUM_REQ-1:0] win, sel;
  logic [127:0] sh;
  logic [3:0] lcnt, ocnt;
  logic [63:0] res;
  logic go, take, done, tmo;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (.req(req), .ptr(ptr), .win(win));

  assign go = state_q == IDLE && |req && !mul_reset;
  assign take = (state_q == WAIT || state_q == COLLECT) && mul_ready;
  assign done = state_q == DRAIN && !mul_ready;
  assign widx = IW'(oh2idx(8'(win)));

`ifdef FP_MULT_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmr;
  assign tmo = state_q inside {WAIT, COLLECT, DRAIN} && tmr == TW'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) tmr <= '0;
    else tmr <= state_q inside {WAIT, COLLECT, DRAIN} ? tmr + 1'b1 : '0;
`else
  logic unused_timeout;
  assign unused_timeout = TIMEOUT != 0;
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (go) state_d = LOAD;
      LOAD:    if (lcnt == 4'(FP_IN_BYTES - 1)) state_d = WAIT;
      WAIT:    if (mul_ready) state_d = COLLECT;
      COLLECT: if (mul_ready && ocnt == 4'(FP_OUT_BYTES - 1)) state_d = DRAIN;
      DRAIN:   if (!mul_ready) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (tmo) state_d = RESP;
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state_q <= IDLE;
    else state_q <= state_d;

  // Operand shift register streams A then B, least significant byte first
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr         <= IW'(NUM_REQ - 1);
      sel         <= '0;
      sh          <= '0;
      lcnt        <= '0;
      ocnt        <= '0;
      res         <= '0;
      gnt         <= '0;
      res_valid   <= '0;
      res_data    <= '0;
      res_err     <= 1'b0;
      mul_reset   <= 1'b1;
      mul_enable  <= 1'b0;
      mul_data_in <= '0;
    end else begin
      mul_reset  <= tmo;
      gnt        <= go ? win : '0;
      mul_enable <= state_q == LOAD;
      lcnt       <= state_q == LOAD ? lcnt + 1'b1 : '0;
      ocnt       <= state_q == LOAD ? '0 : ocnt + 4'(take);
      res_valid  <= done || tmo ? sel : '0;
      res_err    <= tmo;
      if (go) begin
        sel <= win;
        ptr <= widx;
        sh  <= {req_b[64*widx +: 64], req_a[64*widx +: 64]};
      end
      if (state_q == LOAD) begin
        mul_data_in <= sh[7:0];
        sh          <= sh >> 8;
      end
      if (take) res <= {mul_data_out, res[63:8]};
      if (done || tmo) res_data <= tmo ? QNAN : res;
    end
  end
endmodule

// File: tb/tb_fp_mult_arbiter.sv
// tb_fp_mult_arbiter: random and directed jobs against a behavioural fp_mult model and a result scoreboard
module tb_fp_mult_arbiter;
  import fp_mult_pkg::*;
  localparam int N = 4;
`ifdef FP_MULT_ARB_TIMEOUT_EN
  localparam int TMO = 20;
`else
  localparam int TMO = 64;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic [N-1:0] req;
  logic [64*N-1:0] req_a, req_b;
  logic [N-1:0] gnt, res_valid;
  logic [63:0] res_data;
  logic res_err, mul_reset, mul_enable, mul_ready;
  logic [7:0] mul_data_in, mul_data_out;

  always #5 clk = ~clk;

  fp_mult_arbiter #(.NUM_REQ(N), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .res_valid(res_valid), .res_data(res_data), .res_err(res_err),
    .mul_reset(mul_reset), .mul_enable(mul_enable), .mul_data_in(mul_data_in),
    .mul_data_out(mul_data_out), .mul_ready(mul_ready)
  );

  typedef struct {int idx; logic [63:0] data; logic err;} exp_t;
  exp_t sbq[$];
  logic [127:0] jq [N][$];
  int glog[$];
  int n_cmp = 0, n_bad = 0;
  int mr_cnt = 0, stray = 0, en_total = 0, extra_ready = 0;
  bit rand_extra = 0, never_ready = 0, expect_tmo = 0;
  logic [63:0] last_data = '0;
  logic [127:0] last_buf = '0;

  // Reference fp_mult behaviour: NaN in gives canonical qNaN, 0 x inf gives its invalid marker
  function automatic logic [63:0] fmul(input logic [63:0] a, input logic [63:0] b);
    logic an, bn, az, bz, ai, bi;
    an = a[62:52] == 11'h7FF && a[51:0] != 0;
    bn = b[62:52] == 11'h7FF && b[51:0] != 0;
    ai = a[62:0] == 63'h7FF0_0000_0000_0000;
    bi = b[62:0] == 63'h7FF0_0000_0000_0000;
    az = a[62:0] == 0;
    bz = b[62:0] == 0;
    if (an || bn) return QNAN;
    if ((az && bi) || (ai && bz)) return 64'h7FF0_0000_0000_0001;
    return $realtobits($bitstoreal(a) * $bitstoreal(b));
  endfunction

  function automatic logic [63:0] rnd_d();
    return {1'($urandom), 11'h3E0 + 11'($urandom_range(0, 63)), 20'($urandom), 32'($urandom)};
  endfunction

  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) if (r[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  function automatic int pending();
    int p = sbq.size() + int'(req != 0);
    for (int i = 0; i < N; i++) p += jq[i].size();
    return p;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic settle(input int budget);
    int c = 0;
    while (pending() != 0 && c < budget) begin
      @(posedge clk);
      c++;
    end
    if (c >= budget) begin
      n_cmp++;
      n_bad++;
      $display("FAIL settle: %0d jobs still pending after %0d cycles, required 0", pending(), budget);
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk) reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Byte-serial multiplier model, evaluated on the falling edge
  initial begin : mult_model
    logic [127:0] mb;
    logic [63:0] prod;
    int cnt, lat, outn, extra, phase;
    mb = '0; prod = '0; cnt = 0; lat = 0; outn = 0; extra = 0; phase = 0;
    mul_ready = 1'b0;
    mul_data_out = '0;
    forever begin
      @(negedge clk);
      if (mul_enable) en_total++;
      if (mul_reset) begin
        phase = 0; cnt = 0; mul_ready = 1'b0;
      end else if (phase == 0) begin
        if (mul_enable) begin
          mb[cnt*8 +: 8] = mul_data_in;
          cnt++;
          if (cnt == 16) begin
            phase = 1; cnt = 0;
            lat = $urandom_range(1, 3);
            extra = rand_extra ? $urandom_range(0, 2) : extra_ready;
            prod = fmul(mb[63:0], mb[127:64]);
            last_buf = mb;
          end
        end
      end else begin
        if (mul_enable) stray++;
        if (phase == 1) begin
          if (!never_ready) lat--;
          if (lat == 0) begin phase = 2; outn = 0; end
        end else if (outn < 8 + extra) begin
          mul_ready = 1'b1;
          mul_data_out = outn < 8 ? prod[outn*8 +: 8] : 8'hEE;
          outn++;
        end else begin
          mul_ready = 1'b0;
          phase = 0;
        end
      end
    end
  end

  // Clients hold REQ and operands until GNT, then move to their next queued job
  initial begin : driver
    logic [127:0] op;
    req = '0; req_a = '0; req_b = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++)
        if (!req[i] || gnt[i]) begin
          if (jq[i].size() > 0) begin
            op = jq[i].pop_front();
            req_a[64*i +: 64] = op[63:0];
            req_b[64*i +: 64] = op[127:64];
            req[i] = 1'b1;
          end else req[i] = 1'b0;
        end
    end
  end

  initial begin : monitor
    int last, pick, gidx;
    exp_t e;
    last = N - 1;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
        sbq.delete();
        last = N - 1;
        continue;
      end
      if (mul_reset) mr_cnt++;
      if (gnt != 0) begin
        pick = rr_pick(req, last);
        chk("gnt_rr", gnt, pick < 0 ? 128'd0 : 128'(1) << pick);
        gidx = 0;
        for (int k = 0; k < N; k++) if (gnt[k]) gidx = k;
        glog.push_back(gidx);
        last = gidx;
        sbq.push_back('{gidx, expect_tmo ? QNAN : fmul(req_a[64*gidx +: 64], req_b[64*gidx +: 64]), expect_tmo});
      end
      if (res_valid != 0) begin
        last_data = res_data;
        if (sbq.size() == 0) chk("res_unexpected", res_valid, 0);
        else begin
          e = sbq.pop_front();
          chk("res_client", res_valid, 128'(1) << e.idx);
          chk("res_data", res_data, e.data);
          chk("res_err", res_err, e.err);
        end
      end
    end
  end

  initial begin : main
    int en0, mr0, c;
    int rr_exp[5] = '{0, 1, 3, 0, 1};
    logic [63:0] x, y;
    #1 reset_n = 1'b0;
    #1;
    chk("reset_mul_reset", mul_reset, 1);
    chk("reset_outputs", {gnt, res_valid, res_err, mul_enable, mul_data_in, res_data}, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1 chk("mul_reset_hold", mul_reset, 1);
    @(posedge clk);
    #1 chk("mul_reset_clear", mul_reset, 0);

    en0 = en_total;
    jq[0].push_back({64'h4008_0000_0000_0000, 64'h4000_0000_0000_0000});
    settle(300);
    chk("mul_2x3", last_data, 64'h4018_0000_0000_0000);
    chk("load_bytes", last_buf, {64'h4008_0000_0000_0000, 64'h4000_0000_0000_0000});
    chk("enable_cycles", en_total - en0, 16);

    do_reset();
    glog.delete();
    for (int j = 0; j < 2; j++) begin
      jq[0].push_back({rnd_d(), rnd_d()});
      jq[1].push_back({rnd_d(), rnd_d()});
      jq[3].push_back({rnd_d(), rnd_d()});
    end
    settle(1000);
    chk("rr_count", glog.size(), 6);
    for (int k = 0; k < 5; k++) chk("rr_order", glog[k], rr_exp[k]);

    jq[2].push_back({64'h3FF0_0000_0000_0000, 64'h7FF8_0000_0000_0000});
    settle(300);
    chk("nan_prop", last_data, 64'h7FF8_0000_0000_0000);
    jq[1].push_back({64'h7FF0_0000_0000_0000, 64'h0});
    settle(300);
    chk("zero_inf", last_data, 64'h7FF0_0000_0000_0001);

    extra_ready = 1;
    x = rnd_d();
    y = rnd_d();
    jq[3].push_back({y, x});
    settle(300);
    chk("overrun_job", last_data, $realtobits($bitstoreal(x) * $bitstoreal(y)));
    extra_ready = 0;
    jq[2].push_back({rnd_d(), rnd_d()});
    settle(300);

    rand_extra = 1;
    for (int j = 0; j < 40; j++) jq[$urandom_range(0, N - 1)].push_back({rnd_d(), rnd_d()});
    settle(4000);
    rand_extra = 0;

    en0 = en_total;
    jq[0].push_back({rnd_d(), rnd_d()});
    c = 0;
    while (en_total - en0 < 5 && c < 200) begin
      @(posedge clk);
      c++;
    end
    chk("reset_mid_load_reached", int'(c < 200), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_mul_reset", mul_reset, 1);
    chk("abort_outputs", {gnt, res_valid, res_err, mul_enable, mul_data_in, res_data}, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1 chk("abort_mul_reset_hold", mul_reset, 1);
    @(posedge clk);
    #1 chk("abort_mul_reset_clear", mul_reset, 0);
    repeat (40) @(posedge clk);
    jq[2].push_back({64'h4008_0000_0000_0000, 64'h4000_0000_0000_0000});
    settle(300);
    chk("after_abort", last_data, 64'h4018_0000_0000_0000);

`ifdef FP_MULT_ARB_TIMEOUT_EN
    never_ready = 1;
    expect_tmo = 1;
    mr0 = mr_cnt;
    jq[1].push_back({rnd_d(), rnd_d()});
    settle(300);
    chk("tmo_mul_reset_pulses", mr_cnt - mr0, 1);
    chk("tmo_data", last_data, QNAN);
    never_ready = 0;
    expect_tmo = 0;
    jq[3].push_back({64'h4008_0000_0000_0000, 64'h4000_0000_0000_0000});
    settle(300);
    chk("after_tmo", last_data, 64'h4018_0000_0000_0000);
`endif

    chk("stray_enable", stray, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
